// File: rtl/antirebote_pkg.sv
// Shared types and default constants for the multi-channel button debouncer.
package antirebote_pkg;

  typedef enum logic {
    StIdle,
    StLock
  } ch_state_e;

  localparam int unsigned LOCK_CYCLES_DEF = 2500000;
  localparam int unsigned HOLD_CYCLES_DEF = 50000000;

endpackage

// File: rtl/antirebote_ch.sv
// Single debounce channel: 2-flop sync, lockout-based edge acceptance, optional long press.
// Long-press detection is built only when ANTIREBOTE_LONG_PRESS_EN is defined.
module antirebote_ch
  import antirebote_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton_i,
  output logic nivel_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CntW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CntW-1:0] LockLoad = CntW'(LOCK_CYCLES);
  localparam logic RelVal = ACTIVE_LOW;

  if (LOCK_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_chk
    $error("LOCK_CYCLES and HOLD_CYCLES must be >= 1");
  end

  logic [1:0]      sync_q;
  logic            s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            nivel_q, nivel_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  ch_state_e       st;

  // Reset parks the synchronizer at the released level so a held button is a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RelVal}};
    end else begin
      sync_q <= {sync_q[0], boton_i};
    end
  end

  assign s  = sync_q[1] ^ ACTIVE_LOW;
  assign st = (cnt_q == '0) ? StIdle : StLock;

  always_comb begin
    nivel_d   = nivel_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (st)
      StIdle: begin
        if (s != nivel_q) begin
          nivel_d   = s;
          cnt_d     = LockLoad;
          press_d   = s;
          release_d = ~s;
        end
      end
      StLock:  cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      nivel_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      nivel_q   <= nivel_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign nivel_o   = nivel_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef ANTIREBOTE_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Counter saturates at HoldMax so the pulse fires once per press; a same-edge release wins.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (nivel_q) begin
      hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
      long_d = nivel_d && (hold_q == HoldMax - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/antirebote_multi.sv
// N_CH independent button debouncers with press/release/long-press pulses.
// Long press is enabled by defining ANTIREBOTE_LONG_PRESS_EN.
module antirebote_multi
  import antirebote_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] boton_i,
  output logic [N_CH-1:0] nivel_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    antirebote_ch #(
      .LOCK_CYCLES(LOCK_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .boton_i  (boton_i[i]),
      .nivel_o  (nivel_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .long_o   (long_o[i])
    );
  end

endmodule
